// File: rtl/dmem_dp_llsc_if.sv
// One memory access port: a core drives the request side (master),
// the shared data memory answers on the response side (slave).
interface dmem_dp_llsc_if #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 32
);
    localparam int NB = WIDTH / 8;

    logic              req;
    logic              we;
    logic              ll;
    logic              sc;
    logic [NB-1:0]     be;
    logic [ADDR_W-1:0] addr;
    logic [WIDTH-1:0]  wdata;
    logic              gnt;
    logic              done;
    logic [WIDTH-1:0]  rdata;
    logic              sc_ok;

    modport master (
        output req, we, ll, sc, be, addr, wdata,
        input  gnt, done, rdata, sc_ok
    );

    modport slave (
        input  req, we, ll, sc, be, addr, wdata,
        output gnt, done, rdata, sc_ok
    );
endinterface

// File: rtl/dmem_dp_llsc.sv
// Dual-port word memory shared by two cores. Byte-write enables, 1-cycle
// registered reads, port A wins same-word conflicts, and one LL/SC
// reservation per port gives atomic read-modify-write between the cores.
module dmem_dp_llsc #(
    parameter int DEPTH  = 128,
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 32
) (
    input  logic           CLK,
    input  logic           RSTB,
    dmem_dp_llsc_if.slave  port_a,
    dmem_dp_llsc_if.slave  port_b
);
    localparam int NB    = WIDTH / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int IDX_W = $clog2(DEPTH);

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
    } resv_t;

    logic [WIDTH-1:0] mem [DEPTH];

    logic [IDX_W-1:0] idx_a, idx_b;
    logic             conflict;
    logic             gnt_a, gnt_b;
    logic             ll_gnt_a, ll_gnt_b;
    logic             sc_gnt_a, sc_gnt_b;
    logic             sc_pass_a, sc_pass_b;
    logic             wr_a, wr_b;
    logic             clr_a, clr_b;
    resv_t            resv_a, resv_b;
    logic             done_a, done_b;
    logic [WIDTH-1:0] rdata_a, rdata_b;
    logic             sc_ok_a, sc_ok_b;
    logic             unused_addr_bits;

    // Word index: upper bits alias modulo DEPTH, byte-offset bits are dropped.
    assign idx_a = port_a.addr[OFF_W+IDX_W-1:OFF_W];
    assign idx_b = port_b.addr[OFF_W+IDX_W-1:OFF_W];
    assign unused_addr_bits = ^{port_a.addr, port_b.addr};

    // Same word with at least one writer stalls B; two readers share freely.
    assign conflict = port_a.req & port_b.req & (idx_a == idx_b) & (port_a.we | port_b.we);
    assign gnt_a    = RSTB & port_a.req;
    assign gnt_b    = RSTB & port_b.req & ~conflict;

    assign ll_gnt_a  = gnt_a & ~port_a.we & port_a.ll;
    assign ll_gnt_b  = gnt_b & ~port_b.we & port_b.ll;
    assign sc_gnt_a  = gnt_a & port_a.we & port_a.sc;
    assign sc_gnt_b  = gnt_b & port_b.we & port_b.sc;
    assign sc_pass_a = resv_a.valid & (resv_a.idx == idx_a);
    assign sc_pass_b = resv_b.valid & (resv_b.idx == idx_b);

    // A write with no byte lanes enabled or a failed SC touches nothing.
    assign wr_a = gnt_a & port_a.we & (|port_a.be) & ~(port_a.sc & ~sc_pass_a);
    assign wr_b = gnt_b & port_b.we & (|port_b.be) & ~(port_b.sc & ~sc_pass_b);

    // Any performed write to a reserved word breaks that reservation.
    assign clr_a = (wr_a & (resv_a.idx == idx_a)) | (wr_b & (resv_a.idx == idx_b));
    assign clr_b = (wr_a & (resv_b.idx == idx_a)) | (wr_b & (resv_b.idx == idx_b));

    // Byte-lane writes from both ports; conflicts guarantee distinct words.
    // NOTE: the array has no reset, so it maps onto plain RAM; writes are
    // already suppressed in reset because neither port is granted then.
    always_ff @(posedge CLK) begin
        for (int i = 0; i < NB; i++) begin
            if (wr_a && port_a.be[i]) mem[idx_a][8*i +: 8] <= port_a.wdata[8*i +: 8];
            if (wr_b && port_b.be[i]) mem[idx_b][8*i +: 8] <= port_b.wdata[8*i +: 8];
        end
    end

    // Registered read data, done pulses and SC results; held between accesses.
    // NOTE: non-blocking assignment makes a read see the word as it was
    // before a write landing on the same edge.
    always_ff @(posedge CLK) begin
        if (!RSTB) begin
            done_a  <= 1'b0;
            done_b  <= 1'b0;
            rdata_a <= '0;
            rdata_b <= '0;
            sc_ok_a <= 1'b0;
            sc_ok_b <= 1'b0;
        end else begin
            done_a <= gnt_a;
            done_b <= gnt_b;
            if (gnt_a && !port_a.we) rdata_a <= mem[idx_a];
            if (gnt_b && !port_b.we) rdata_b <= mem[idx_b];
            if (sc_gnt_a) sc_ok_a <= sc_pass_a;
            if (sc_gnt_b) sc_ok_b <= sc_pass_b;
        end
    end

    // Reservations: cleared by writes and SCs, then (re)armed by an LL.
    always_ff @(posedge CLK) begin
        if (!RSTB) begin
            resv_a <= '0;
            resv_b <= '0;
        end else begin
            if (clr_a || sc_gnt_a) resv_a.valid <= 1'b0;
            if (clr_b || sc_gnt_b) resv_b.valid <= 1'b0;
            if (ll_gnt_a) resv_a <= '{valid: 1'b1, idx: idx_a};
            if (ll_gnt_b) resv_b <= '{valid: 1'b1, idx: idx_b};
        end
    end

    assign port_a.gnt   = gnt_a;
    assign port_b.gnt   = gnt_b;
    assign port_a.done  = done_a;
    assign port_b.done  = done_b;
    assign port_a.rdata = rdata_a;
    assign port_b.rdata = rdata_b;
    assign port_a.sc_ok = sc_ok_a;
    assign port_b.sc_ok = sc_ok_b;
endmodule

// File: tb/tb_dmem_dp_llsc.sv
// Bench for dmem_dp_llsc: a reference memory/reservation model predicts
// every response when a request is granted; a monitor pops and compares.
module tb_dmem_dp_llsc;
    logic clk = 1'b0;
    logic rstb = 1'b0;
    always #5 clk = ~clk;

    // Bench-side drive signals, index 0 = port A, 1 = port B.
    logic [1:0]       req = '0, we = '0, ll = '0, sc = '0;
    logic [1:0][3:0]  be = '0;
    logic [1:0][31:0] addr = '0, wdata = '0;
    logic [1:0]       gnt, done, sc_ok;
    logic [1:0][31:0] rdata;

    dmem_dp_llsc_if #(.WIDTH(32), .ADDR_W(32)) pa ();
    dmem_dp_llsc_if #(.WIDTH(32), .ADDR_W(32)) pb ();

    assign pa.req = req[0];  assign pa.we = we[0];  assign pa.ll = ll[0];  assign pa.sc = sc[0];
    assign pa.be = be[0];    assign pa.addr = addr[0];  assign pa.wdata = wdata[0];
    assign pb.req = req[1];  assign pb.we = we[1];  assign pb.ll = ll[1];  assign pb.sc = sc[1];
    assign pb.be = be[1];    assign pb.addr = addr[1];  assign pb.wdata = wdata[1];
    assign gnt   = {pb.gnt, pa.gnt};
    assign done  = {pb.done, pa.done};
    assign sc_ok = {pb.sc_ok, pa.sc_ok};
    assign rdata = {pb.rdata, pa.rdata};

    dmem_dp_llsc #(.DEPTH(128), .WIDTH(32), .ADDR_W(32)) dut (
        .CLK    (clk),
        .RSTB   (rstb),
        .port_a (pa),
        .port_b (pb)
    );

    typedef struct {
        logic        is_rd;
        logic        is_sc;
        logic [31:0] data;
        logic        ok;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];

    logic [31:0] ref_mem [128];
    logic [1:0]  rv = '0;
    logic [6:0]  ri [2];

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model, applied at the grant edge; same-word hazards between
    // ports cannot occur in one cycle because such a B request is stalled.
    task automatic model(input int p, input logic w, input logic l, input logic s,
                         input logic [3:0] b, input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        logic [6:0] ix;
        logic ok;
        ix = a[8:2];
        e = '{is_rd: 1'b0, is_sc: 1'b0, data: '0, ok: 1'b0};
        if (!w) begin
            e.is_rd = 1'b1;
            e.data  = ref_mem[ix];
            if (l) begin
                rv[p] = 1'b1;
                ri[p] = ix;
            end
        end else begin
            ok = !s || (rv[p] && ri[p] == ix);
            if (s) begin
                e.is_sc = 1'b1;
                e.ok    = ok;
                rv[p]   = 1'b0;
            end
            if (ok && b != 4'h0) begin
                for (int i = 0; i < 4; i++)
                    if (b[i]) ref_mem[ix][8*i +: 8] = d[8*i +: 8];
                for (int q = 0; q < 2; q++)
                    if (ri[q] == ix) rv[q] = 1'b0;
            end
        end
        if (p == 0) q_a.push_back(e);
        else        q_b.push_back(e);
    endtask

    // One access on port p: hold the request until granted (bounded).
    task automatic access(input int p, input logic w, input logic l, input logic s,
                          input logic [3:0] b, input logic [31:0] a, input logic [31:0] d);
        logic got;
        got = 1'b0;
        req[p] = 1'b1; we[p] = w; ll[p] = l; sc[p] = s;
        be[p] = b; addr[p] = a; wdata[p] = d;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (gnt[p]) begin
                got = 1'b1;
                model(p, w, l, s, b, a, d);
            end
        end
        if (!got) check(p == 0 ? "gntA_timeout" : "gntB_timeout", 32'(got), 32'd1);
        @(posedge clk); #1;
        req[p] = 1'b0;
    endtask

    task automatic do_reset(input int cycles);
        rstb = 1'b0;
        rv   = '0;
        repeat (cycles) @(posedge clk);
        #1 rstb = 1'b1;
    endtask

    // Monitor: done must follow exactly the granted accesses; compare payloads.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk); #1;
            check("doneA", 32'(done[0]), 32'(q_a.size() != 0));
            if (q_a.size() != 0) begin
                e = q_a.pop_front();
                if (done[0] && e.is_rd) check("rdataA", rdata[0], e.data);
                if (done[0] && e.is_sc) check("scokA", 32'(sc_ok[0]), 32'(e.ok));
            end
            check("doneB", 32'(done[1]), 32'(q_b.size() != 0));
            if (q_b.size() != 0) begin
                e = q_b.pop_front();
                if (done[1] && e.is_rd) check("rdataB", rdata[1], e.data);
                if (done[1] && e.is_sc) check("scokB", 32'(sc_ok[1]), 32'(e.ok));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held for two cycles with a pending request on A.
        req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h0;
        @(negedge clk);
        check("rst_gntA", 32'(gnt[0]), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        check("rst_doneA", 32'(done[0]), 32'd0);
        check("rst_rdataA", rdata[0], 32'd0);
        check("rst_scokA", 32'(sc_ok[0]), 32'd0);
        req[0] = 1'b0;
        rstb = 1'b1;
        @(posedge clk); #1;

        // Full-word write then cross-port read; then a single-byte update.
        access(0, 1, 0, 0, 4'hF, 32'h10, 32'hDEADBEEF);
        access(1, 0, 0, 0, 4'h0, 32'h10, 32'h0);
        access(0, 1, 0, 0, 4'b0001, 32'h10, 32'h00000011);
        access(1, 0, 0, 0, 4'h0, 32'h10, 32'h0);
        check("byte_merge", ref_mem[4], 32'hDEADBE11);

        // Conflict: A writes 0x20 while B reads alias 0x220; B waits a cycle.
        fork
            access(0, 1, 0, 0, 4'hF, 32'h20, 32'hCAFEF00D);
            access(1, 0, 0, 0, 4'h0, 32'h220, 32'h0);
            begin
                @(negedge clk);
                check("conf_gntA", 32'(gnt[0]), 32'd1);
                check("conf_gntB", 32'(gnt[1]), 32'd0);
                @(negedge clk);
                check("retry_gntB", 32'(gnt[1]), 32'd1);
            end
        join

        // Two reads of the same word: no conflict.
        access(0, 1, 0, 0, 4'hF, 32'h40, 32'h12345678);
        fork
            access(0, 0, 0, 0, 4'h0, 32'h40, 32'h0);
            access(1, 0, 0, 0, 4'h0, 32'h40, 32'h0);
            begin
                @(negedge clk);
                check("rr_gnt", 32'(gnt), 32'd3);
            end
        join

        // LL/SC broken by the other port's store.
        access(0, 1, 0, 0, 4'hF, 32'h80, 32'h0);
        access(0, 0, 1, 0, 4'h0, 32'h80, 32'h0);
        access(1, 1, 0, 0, 4'hF, 32'h80, 32'd5);
        access(0, 1, 0, 1, 4'hF, 32'h80, 32'd7);
        access(1, 0, 0, 0, 4'h0, 32'h80, 32'h0);
        // Undisturbed LL/SC, then a second SC with no reservation.
        access(0, 0, 1, 0, 4'h0, 32'h80, 32'h0);
        access(0, 1, 0, 1, 4'hF, 32'h80, 32'd7);
        access(1, 0, 0, 0, 4'h0, 32'h80, 32'h0);
        access(0, 1, 0, 1, 4'hF, 32'h80, 32'd8);
        // A zero-byte-enable store does not break the reservation.
        access(0, 0, 1, 0, 4'h0, 32'h80, 32'h0);
        access(1, 1, 0, 0, 4'h0, 32'h80, 32'hFFFFFFFF);
        access(0, 1, 0, 1, 4'hF, 32'h80, 32'd9);
        // LL flag ignored on a write; SC flag ignored on a read.
        access(0, 1, 1, 0, 4'hF, 32'h90, 32'hA5A5A5A5);
        access(0, 0, 0, 1, 4'h0, 32'h90, 32'h0);
        access(0, 1, 0, 1, 4'hF, 32'h90, 32'h1);
        access(1, 0, 0, 0, 4'h0, 32'h80, 32'h0);
        access(1, 0, 0, 0, 4'h0, 32'h90, 32'h0);

        // Both ports reserve; A's SC breaks B's reservation.
        fork
            access(0, 0, 1, 0, 4'h0, 32'h80, 32'h0);
            access(1, 0, 1, 0, 4'h0, 32'h80, 32'h0);
        join
        access(0, 1, 0, 1, 4'hF, 32'h80, 32'd11);
        access(1, 1, 0, 1, 4'hF, 32'h80, 32'd3);
        access(0, 0, 0, 0, 4'h0, 32'h80, 32'h0);

        // Reset between LL and SC drops the reservation.
        access(0, 0, 1, 0, 4'h0, 32'h80, 32'h0);
        do_reset(2);
        check("post_rst_scokA", 32'(sc_ok[0]), 32'd0);
        access(0, 1, 0, 1, 4'hF, 32'h80, 32'd13);
        access(1, 0, 0, 0, 4'h0, 32'h80, 32'h0);

        repeat (3) @(posedge clk);
        #2;
        check("qA_empty", 32'(q_a.size()), 32'd0);
        check("qB_empty", 32'(q_b.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
